// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline stages.
package mips_pkg;

  localparam int          WORD_W      = 32;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          IMEM_IDX_HI = 11;
  localparam int          IMEM_IDX_LO = 2;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register carrying an instruction, its PC+4 and a valid bit.
// Flush beats stall so a squash is never lost behind a hazard hold.
module if_id_register
  import mips_pkg::*;
#(
  parameter int                 W       = mips_pkg::WORD_W,
  parameter logic [W-1:0]       NOP_VAL = mips_pkg::NOP_WORD
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Stall,
  input  logic         Flush,
  input  logic [W-1:0] Instruction,
  input  logic [W-1:0] PCPlus4,
  input  logic         Valid,
  output logic [W-1:0] Instruction_ID,
  output logic [W-1:0] PCPlus4_ID,
  output logic         Valid_ID
);

  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pcp4_q, pcp4_d;
  logic         valid_q, valid_d;

  // A flush inserts a bubble but keeps the old PC+4 so downstream sees a stable value.
  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (Flush) begin
      instr_d = NOP_VAL;
      valid_d = 1'b0;
    end else if (!Stall) begin
      instr_d = Instruction;
      pcp4_d  = PCPlus4;
      valid_d = Valid;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_q <= NOP_VAL;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign Instruction_ID = instr_q;
  assign PCPlus4_ID     = pcp4_q;
  assign Valid_ID       = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, next-PC selection, range/alignment checks and fetch count,
// feeding the IF/ID register from the combinational instruction memory.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] ImemAddress,
  output logic [31:0] PC,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic        OutOfRange,
  output logic        MisalignedRedirect,
  output logic [31:0] FetchCount
);
  import mips_pkg::*;

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        oor_q, oor_d;
  logic        mis_q, mis_d;
  logic [31:0] pc_plus4;
  logic        in_range;
  logic        flush;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_range = {1'b0, pc_q} < IMEM_BYTES;

  // Redirect squashes the slot; an out-of-range fetch also lands a bubble while PC parks.
  assign flush = Redirect | (!Stall && !in_range);

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    oor_d   = oor_q;
    mis_d   = mis_q;
    if (Redirect) begin
      pc_d  = word_align(RedirectTarget);
      mis_d = mis_q | (RedirectTarget[1:0] != 2'b00);
    end else if (!Stall) begin
      if (in_range) begin
        pc_d    = pc_plus4;
        oor_d   = 1'b0;
        count_d = count_q + 32'd1;
      end else begin
        oor_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      oor_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      oor_q   <= oor_d;
      mis_q   <= mis_d;
    end
  end

  // Valid_ID=1 means Instruction_ID/PCPlus4_ID hold a real fetched instruction that decode
  // may consume; there is no ready back-pressure other than Stall holding the register.
  if_id_register #(
    .W       (WORD_W),
    .NOP_VAL (NOP_WORD)
  ) u_if_id (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Flush          (flush),
    .Instruction    (ImemInstruction),
    .PCPlus4        (pc_plus4),
    .Valid          (1'b1),
    .Instruction_ID (Instruction_ID),
    .PCPlus4_ID     (PCPlus4_ID),
    .Valid_ID       (Valid_ID)
  );

`ifdef IFETCH_TRACE
  always @(posedge Clk) begin
    if (Reset && !Redirect && !Stall && in_range)
      $display("IF capture pc=%h idx=%0d word=%h", pc_q,
               pc_q[IMEM_IDX_HI:IMEM_IDX_LO], ImemInstruction);
  end
`endif

  assign ImemAddress        = pc_q;
  assign PC                 = pc_q;
  assign OutOfRange         = oor_q;
  assign MisalignedRedirect = mis_q;
  assign FetchCount         = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: reference model + expected queue, plus a
// second instance parked near the top of instruction memory.
module tb_instruction_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic [31:0] count;
    logic        valid;
    logic        oor;
    logic        mis;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_run = 1'b1;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  logic [31:0] mem [1024];

  // main instance
  logic        rst_n, stall, redir;
  logic [31:0] tgt, imem_a, addr_a, pc_a, instr_a, pcp4_a, cnt_a;
  logic        valid_a, oor_a, mis_a;
  assign imem_a = mem[addr_a[11:2]];

  instruction_fetch_stage u_dut (
    .Clk(clk), .Reset(rst_n), .Stall(stall), .Redirect(redir),
    .RedirectTarget(tgt), .ImemInstruction(imem_a), .ImemAddress(addr_a),
    .PC(pc_a), .Instruction_ID(instr_a), .PCPlus4_ID(pcp4_a), .Valid_ID(valid_a),
    .OutOfRange(oor_a), .MisalignedRedirect(mis_a), .FetchCount(cnt_a)
  );

  // range instance starting at the last memory word
  logic        rst2_n, stall2, redir2;
  logic [31:0] tgt2, imem_b, addr_b, pc_b, instr_b, pcp4_b, cnt_b;
  logic        valid_b, oor_b, mis_b;
  assign imem_b = mem[addr_b[11:2]];

  instruction_fetch_stage #(.RESET_PC(32'h0000_0FFC), .IMEM_WORDS(1024)) u_rng (
    .Clk(clk), .Reset(rst2_n), .Stall(stall2), .Redirect(redir2),
    .RedirectTarget(tgt2), .ImemInstruction(imem_b), .ImemAddress(addr_b),
    .PC(pc_b), .Instruction_ID(instr_b), .PCPlus4_ID(pcp4_b), .Valid_ID(valid_b),
    .OutOfRange(oor_b), .MisalignedRedirect(mis_b), .FetchCount(cnt_b)
  );

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t m;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one clock edge.
  function automatic void model_reset();
    m = '0;
  endfunction

  function automatic void model_edge(input bit s, input bit r, input logic [31:0] t);
    if (r) begin
      m.pc    = t & 32'hFFFF_FFFC;
      m.instr = 32'h0;
      m.valid = 1'b0;
      if (t % 4 != 0) m.mis = 1'b1;
    end else if (!s) begin
      if (m.pc < 32'd4096) begin
        m.instr = mem[m.pc / 4];
        m.pcp4  = m.pc + 32'd4;
        m.valid = 1'b1;
        m.oor   = 1'b0;
        m.count = m.count + 32'd1;
        m.pc    = m.pc + 32'd4;
      end else begin
        m.instr = 32'h0;
        m.valid = 1'b0;
        m.oor   = 1'b1;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Called while clk is low; applies inputs for the next rising edge.
  task automatic step(input bit s, input bit r, input logic [31:0] t);
    stall = s;
    redir = r;
    tgt   = t;
    model_edge(s, r, t);
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc",         pc_a,           mon_e.pc);
      chk("imem_addr",  addr_a,         mon_e.pc);
      chk("instr_id",   instr_a,        mon_e.instr);
      chk("pcplus4_id", pcp4_a,         mon_e.pcp4);
      chk("valid_id",   32'(valid_a),   32'(mon_e.valid));
      chk("fetch_count", cnt_a,         mon_e.count);
      chk("out_of_range", 32'(oor_a),   32'(mon_e.oor));
      chk("misaligned", 32'(mis_a),     32'(mon_e.mis));
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          s, r;
    logic [31:0] t;
    stall = 0; redir = 0; tgt = 0;
    stall2 = 0; redir2 = 0; tgt2 = 0;
    rst_n = 1; rst2_n = 1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 3);

    #2 rst_n = 0; rst2_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc",      pc_a,          32'h0);
    chk("rst_instr",   instr_a,       32'h0);
    chk("rst_pcp4",    pcp4_a,        32'h0);
    chk("rst_valid",   32'(valid_a),  32'h0);
    chk("rst_count",   cnt_a,         32'h0);
    chk("rst_oor",     32'(oor_a),    32'h0);
    chk("rst_mis",     32'(mis_a),    32'h0);
    chk("rst_pc_rng",  pc_b,          32'h0000_0FFC);

    // run four words: 0,3,6,9
    rst_n = 1;
    model_reset();
    repeat (4) step(0, 0, 0);
    chk("run_count", cnt_a, 32'd4);
    chk("run_pc",    pc_a,  32'd16);

    // back to PC=8 with word 3 in IF/ID, then stall two cycles
    step(0, 1, 32'h4);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("stall_release", instr_a, 32'd6);

    // redirect during stall, then misaligned and later aligned redirects
    step(1, 1, 32'h40);
    step(0, 0, 0);
    chk("redir_word", instr_a, 32'd48);
    step(0, 1, 32'h23);
    chk("misaligned_pc", pc_a, 32'h20);
    step(0, 0, 0);
    step(0, 1, 32'h80);
    step(0, 0, 0);
    chk("misaligned_sticky", 32'(mis_a), 32'd1);

    // randomized traffic, including parks beyond the memory end
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) t = $urandom_range(32'h0F00, 32'h10FF);
      else                           t = $urandom_range(32'h0, 32'h0FFF);
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(s, r, t);
    end

    // async reset with the clock stopped at PC=0x20
    step(0, 1, 32'h20);
    drain();
    clk_run = 0;
    #3 rst_n = 0;
    #1;
    chk("async_pc",    pc_a,         32'h0);
    chk("async_valid", 32'(valid_a), 32'h0);
    chk("async_count", cnt_a,        32'h0);
    chk("async_instr", instr_a,      32'h0);
    chk("async_mis",   32'(mis_a),   32'h0);
    #2 rst_n = 1;
    model_reset();
    clk_run = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    drain();

    // range instance: last word valid, then park at 0x1000, then recover
    rst2_n = 1;
    @(negedge clk);
    chk("rng_first_valid", 32'(valid_b), 32'd1);
    chk("rng_first_instr", instr_b,      32'd3069);
    chk("rng_first_pcp4",  pcp4_b,       32'h1000);
    chk("rng_first_pc",    pc_b,         32'h1000);
    chk("rng_first_count", cnt_b,        32'd1);
    @(negedge clk);
    chk("rng_park_oor",   32'(oor_b),   32'd1);
    chk("rng_park_valid", 32'(valid_b), 32'd0);
    chk("rng_park_instr", instr_b,      32'h0);
    chk("rng_park_pc",    pc_b,         32'h1000);
    chk("rng_park_count", cnt_b,        32'd1);
    @(negedge clk);
    chk("rng_still_parked", pc_b, 32'h1000);
    redir2 = 1; tgt2 = 32'h0;
    @(negedge clk);
    redir2 = 0;
    chk("rng_redir_pc",    pc_b,         32'h0);
    chk("rng_redir_valid", 32'(valid_b), 32'd0);
    @(negedge clk);
    chk("rng_rec_valid", 32'(valid_b), 32'd1);
    chk("rng_rec_instr", instr_b,      32'h0);
    chk("rng_rec_pc",    pc_b,         32'h4);
    chk("rng_rec_oor",   32'(oor_b),   32'd0);
    chk("rng_rec_count", cnt_b,        32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
